recirculador_param: RTL and testbench
=====================================

# recirculador_param

Parametrised lane recirculator between the serial-to-parallel converter and the L1 mux. Each accepted input word goes to one of two places. If the link is qualified as active, it is forwarded to the L1 mux path. Otherwise it is stored in a small FIFO that drains to the probe/recirculation path under a ready handshake. The `active` input is qualified by a hold-off counter, so a glitching `active` cannot toggle routing.

## Interface
- `LANES`, 4: number of data lanes.
- `LANE_W`, 8: bits per lane.
- `FIFO_DEPTH`, 4: recirculation FIFO entries; power of 2, ≥2.
- `ACT_HOLD`, 2: consecutive `active`=1 cycles required before forwarding; 0 = immediate.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-low.
- `data_in` in LANES*LANE_W: input word; lane i at bits [i*LANE_W +: LANE_W].
- `valid_in` in LANES: per-lane valid.
- `active` in 1: link-active indication from serial-to-parallel.
- `recirc_ready` in 1: probe side accepts the current recirculated word.
- `data_out_active` out LANES*LANE_W: forwarded word to the L1 mux.
- `valid_out_active` out LANES: per-lane valid of the forwarded word.
- `data_out_recirc` out LANES*LANE_W: FIFO head word.
- `valid_out_recirc` out LANES: per-lane valid of the FIFO head; all 0 when FIFO empty.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: FIFO occupancy.
- `fifo_full` out 1: `fifo_count`==FIFO_DEPTH.
- `fwd_count` out CNT_W: words forwarded; wraps.
- `drop_count` out CNT_W: words dropped on full FIFO; saturates at all-ones.

## Operation
- **Word accepted** when |`valid_in`. Lanes whose `valid_in` bit is 0 are stored and output as zero data.
- **FSM states:** INACT, ARMING, ACT.
  - INACT: if `active`=1 and ACT_HOLD=0, go to ACT. If `active`=1 and ACT_HOLD>0, go to ARMING with hold counter = 1.
  - ARMING: if `active`=0, go to INACT. Else increment the hold counter; when it reaches ACT_HOLD, go to ACT.
  - ACT: if `active`=0, go to INACT.
- **Routing** uses the state register value in the cycle the word is accepted, not the next state.
  - ACT: forward path.
  - INACT or ARMING: FIFO push.
- **Forward path:** registered.
  - `data_out_active`/`valid_out_active` load the masked word on an accepted ACT-routed word; otherwise `valid_out_active` goes to 0 and data holds.
  - `fwd_count` increments per forwarded word.
- **FIFO:** show-ahead.
  - Head is driven from memory at the read pointer; `valid_out_recirc` = stored lane valids when non-empty, else 0.
  - Pop when `fifo_count`>0 and `recirc_ready`=1.
  - Push when a word is routed to the recirc path and (not full, or pop in the same cycle).
  - Push and pop in the same cycle: count unchanged, both pointers advance, including when full.
  - Push on full with no pop: word discarded, `drop_count`+1 (saturating), FIFO contents unchanged.
  - Pop on empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- **Forwarded words bypass the FIFO.** FIFO contents keep draining to the probe side regardless of state; they are never replayed to the L1 path.

## Timing
- **Reset** (`reset`=0 at an edge):
  - State INACT, hold counter 0, pointers 0, `fifo_count` 0, `fifo_full` 0.
  - `data_out_active` 0, `valid_out_active` 0, `valid_out_recirc` 0, `data_out_recirc` 0.
  - `fwd_count` 0, `drop_count` 0.
  - Any input in a reset cycle is ignored.
  - Reset mid-operation discards FIFO contents and takes effect at that edge.
- **Forward latency:** 1 cycle (word at edge N appears after edge N).
- **Recirc latency:** a word pushed at edge N into an empty FIFO is at the head after edge N; earliest pop is edge N+1.
- **Activation delay:** with `active` rising before edge N, the state is ACT after edge N+ACT_HOLD−1 (ACT_HOLD≥1) or after edge N (ACT_HOLD=0). Words accepted at or before that edge still go to the FIFO.
- **Deactivation:** `active` falling before edge N gives INACT after edge N. The word accepted at edge N is still forwarded.
- **Handshake:** `data_out_recirc` is stable while `valid_out_recirc`≠0 and `recirc_ready`=0.

## Test plan
- **Reset:** hold `reset`=0 3 cycles with `valid_in`=4'hF → all outputs and counters 0, `fifo_count`=0.
- **Arming (ACT_HOLD=2):**
  - `active`=1 from cycle 0, words 0x11223344..., one per cycle.
  - First 2 words go to the FIFO; the 3rd appears on `data_out_active` one cycle later with `valid_out_active`=4'hF.
  - `fwd_count` increments from then on.
- **Lane masking:** ACT state, `data_in`=0xAABBCCDD, `valid_in`=4'b0101 → `data_out_active`=0x00BB00DD, `valid_out_active`=4'b0101.
- **Overflow:**
  - INACT, `recirc_ready`=0, 6 words → `fifo_full`=1 after 4 pushes, `drop_count`=2.
  - Head stays word 1; then with `recirc_ready`=1, words 1–4 drain in order, one per cycle.
- **Full push+pop:** FIFO full, `recirc_ready`=1, new word pushed in the same cycle → `fifo_count` stays 4, no drop, new word exits 4th.
- **Glitch rejection:** `active` pulses 1 for 1 cycle (ACT_HOLD=2) → state never reaches ACT; all words go to the FIFO; `fwd_count`=0.

Source files
------------

// File: rtl/recirculador_param.sv
// Lane recirculator: accepted words go to the L1 forward path once the link is
// qualified active; otherwise they queue in a show-ahead FIFO toward the probe side.
module recirculador_param #(
    parameter int LANES      = 4,
    parameter int LANE_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ACT_HOLD   = 2,
    parameter int CNT_W      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [LANES*LANE_W-1:0]        data_in,
    input  logic [LANES-1:0]               valid_in,
    input  logic                           active,
    input  logic                           recirc_ready,
    output logic [LANES*LANE_W-1:0]        data_out_active,
    output logic [LANES-1:0]               valid_out_active,
    output logic [LANES*LANE_W-1:0]        data_out_recirc,
    output logic [LANES-1:0]               valid_out_recirc,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           fifo_full,
    output logic [CNT_W-1:0]               fwd_count,
    output logic [CNT_W-1:0]               drop_count
);

    localparam int WORD_W = LANES * LANE_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = PTR_W + 1;
    localparam int HOLD_W = $clog2(ACT_HOLD + 2);
    localparam int ENT_W  = WORD_W + LANES;

    typedef enum logic [1:0] {INACT, ARMING, ACT} state_t;

    state_t            state, state_next;
    logic [HOLD_W-1:0] hold_cnt, hold_next;

    logic [WORD_W-1:0] fwd_data_p1;
    logic [LANES-1:0]  vld_p1;

    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [ENT_W-1:0]  head;
    logic              fifo_empty;

    logic              accepted, route_fwd, route_recirc;
    logic              push, pop, drop;
    logic [WORD_W-1:0] masked;

    function automatic logic [WORD_W-1:0] mask_word(input logic [WORD_W-1:0] d,
                                                    input logic [LANES-1:0]  v);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++)
            m[i*LANE_W +: LANE_W] = v[i] ? d[i*LANE_W +: LANE_W] : '0;
        return m;
    endfunction

    // A hold of 0 or 1 qualifies on the first active edge; longer holds count through ARMING.
    always_comb begin
        state_next = state;
        hold_next  = hold_cnt;
        case (state)
            INACT: begin
                if (active) begin
                    if (ACT_HOLD <= 1) begin
                        state_next = ACT;
                        hold_next  = '0;
                    end else begin
                        state_next = ARMING;
                        hold_next  = HOLD_W'(1);
                    end
                end
            end
            ARMING: begin
                if (!active) begin
                    state_next = INACT;
                    hold_next  = '0;
                end else if (hold_cnt + HOLD_W'(1) == HOLD_W'(ACT_HOLD)) begin
                    state_next = ACT;
                    hold_next  = '0;
                end else begin
                    hold_next = hold_cnt + HOLD_W'(1);
                end
            end
            ACT: begin
                if (!active) begin
                    state_next = INACT;
                    hold_next  = '0;
                end
            end
            default: begin
                state_next = INACT;
                hold_next  = '0;
            end
        endcase
    end

    assign accepted     = |valid_in;
    assign route_fwd    = accepted && (state == ACT);
    assign route_recirc = accepted && (state != ACT);
    assign masked       = mask_word(data_in, valid_in);

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FCNT_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && recirc_ready;
    assign push       = route_recirc && (!fifo_full || pop);
    assign drop       = route_recirc && fifo_full && !pop;

    assign head             = mem[rd_ptr];
    assign data_out_recirc  = fifo_empty ? '0 : head[WORD_W-1:0];
    assign valid_out_recirc = fifo_empty ? '0 : head[WORD_W +: LANES];

    assign data_out_active  = fwd_data_p1;
    assign valid_out_active = vld_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= INACT;
            hold_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            fwd_count  <= '0;
            drop_count <= '0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_count <= fifo_count + FCNT_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - FCNT_W'(1);
            if (route_fwd)
                fwd_count <= fwd_count + CNT_W'(1);
            if (drop && (drop_count != '1))
                drop_count <= drop_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {valid_in, masked};
    end

    // p1: registered forward stage; data holds when no word is forwarded
    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_data_p1 <= '0;
            vld_p1      <= '0;
        end else if (route_fwd) begin
            fwd_data_p1 <= masked;
            vld_p1      <= valid_in;
        end else begin
            vld_p1 <= '0;
        end
    end

endmodule

// File: tb/tb_recirculador_param.sv
// Bench for recirculador_param: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a queue-based model.
module tb_recirculador_param;

    localparam int LANES      = 4;
    localparam int LANE_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int ACT_HOLD   = 2;
    localparam int CNT_W      = 16;
    localparam int WORD_W     = LANES * LANE_W;
    localparam int HOLD_EFF   = (ACT_HOLD < 1) ? 1 : ACT_HOLD;

    typedef logic [WORD_W+LANES-1:0] ent_t;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [WORD_W-1:0]           data_in;
    logic [LANES-1:0]            valid_in;
    logic                        active;
    logic                        recirc_ready;
    logic [WORD_W-1:0]           data_out_active;
    logic [LANES-1:0]            valid_out_active;
    logic [WORD_W-1:0]           data_out_recirc;
    logic [LANES-1:0]            valid_out_recirc;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;
    logic [CNT_W-1:0]            fwd_count;
    logic [CNT_W-1:0]            drop_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    recirculador_param #(
        .LANES(LANES), .LANE_W(LANE_W), .FIFO_DEPTH(FIFO_DEPTH),
        .ACT_HOLD(ACT_HOLD), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .active(active), .recirc_ready(recirc_ready),
        .data_out_active(data_out_active), .valid_out_active(valid_out_active),
        .data_out_recirc(data_out_recirc), .valid_out_recirc(valid_out_recirc),
        .fifo_count(fifo_count), .fifo_full(fifo_full),
        .fwd_count(fwd_count), .drop_count(drop_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mask(input logic [WORD_W-1:0] d, input logic [LANES-1:0] v);
        logic [WORD_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++)
            if (v[i]) m[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W];
        return m;
    endfunction

    // Model: link is qualified once 'active' has been seen on HOLD_EFF consecutive edges.
    ent_t              q[$];
    int                run = 0;
    logic [WORD_W-1:0] m_fwd_data = '0;
    logic [LANES-1:0]  m_fwd_vld = '0;
    int                m_fwd_cnt = 0;
    int                m_drop_cnt = 0;
    bit                started = 0;

    always @(posedge clk) begin : model
        bit act_now;
        if (!reset) begin
            q.delete();
            run        = 0;
            m_fwd_data = '0;
            m_fwd_vld  = '0;
            m_fwd_cnt  = 0;
            m_drop_cnt = 0;
        end else begin
            act_now = (run >= HOLD_EFF);
            if (q.size() > 0 && recirc_ready) void'(q.pop_front());
            m_fwd_vld = '0;
            if (|valid_in) begin
                if (act_now) begin
                    m_fwd_data = mask(data_in, valid_in);
                    m_fwd_vld  = valid_in;
                    m_fwd_cnt  = (m_fwd_cnt + 1) % (1 << CNT_W);
                end else if (q.size() < FIFO_DEPTH) begin
                    q.push_back({valid_in, mask(data_in, valid_in)});
                end else if (m_drop_cnt < (1 << CNT_W) - 1) begin
                    m_drop_cnt = m_drop_cnt + 1;
                end
            end
            run = active ? ((run < 1000) ? run + 1 : run) : 0;
        end
        started = 1;
    end

    always @(negedge clk) begin : compare
        ent_t h;
        if (started) begin
            h = (q.size() > 0) ? q[0] : '0;
            chk("data_out_active",  64'(data_out_active),  64'(m_fwd_data));
            chk("valid_out_active", 64'(valid_out_active), 64'(m_fwd_vld));
            chk("data_out_recirc",  64'(data_out_recirc),  64'(h[WORD_W-1:0]));
            chk("valid_out_recirc", 64'(valid_out_recirc), 64'(h[WORD_W +: LANES]));
            chk("fifo_count",       64'(fifo_count),       64'(q.size()));
            chk("fifo_full",        64'(fifo_full),        64'(q.size() == FIFO_DEPTH));
            chk("fwd_count",        64'(fwd_count),        64'(m_fwd_cnt));
            chk("drop_count",       64'(drop_count),       64'(m_drop_cnt));
        end
    end

    task automatic step(input logic r, input logic a, input logic [LANES-1:0] v,
                        input logic [WORD_W-1:0] d, input logic rdy);
        reset        = r;
        active       = a;
        valid_in     = v;
        data_in      = d;
        recirc_ready = rdy;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [WORD_W-1:0] w;
        logic              a;
        reset = 1'b0; active = 1'b0; valid_in = '0; data_in = '0; recirc_ready = 1'b0;

        // Reset with traffic present
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1);
        chk("lit_rst_fifo_count", 64'(fifo_count), 64'd0);
        chk("lit_rst_fifo_full",  64'(fifo_full), 64'd0);
        chk("lit_rst_data_act",   64'(data_out_active), 64'd0);
        chk("lit_rst_vld_act",    64'(valid_out_active), 64'd0);
        chk("lit_rst_data_rec",   64'(data_out_recirc), 64'd0);
        chk("lit_rst_vld_rec",    64'(valid_out_recirc), 64'd0);
        chk("lit_rst_fwd",        64'(fwd_count), 64'd0);
        chk("lit_rst_drop",       64'(drop_count), 64'd0);

        // Arming: first two words queue, third is forwarded
        step(1'b1, 1'b1, 4'hF, 32'h11223344, 1'b0);
        chk("lit_arm_cnt1", 64'(fifo_count), 64'd1);
        chk("lit_arm_vld0", 64'(valid_out_active), 64'd0);
        step(1'b1, 1'b1, 4'hF, 32'h11223345, 1'b0);
        chk("lit_arm_cnt2", 64'(fifo_count), 64'd2);
        step(1'b1, 1'b1, 4'hF, 32'h11223346, 1'b0);
        chk("lit_arm_fwd_data", 64'(data_out_active), 64'h11223346);
        chk("lit_arm_fwd_vld",  64'(valid_out_active), 64'hF);
        chk("lit_arm_fwd_cnt",  64'(fwd_count), 64'd1);
        chk("lit_arm_head",     64'(data_out_recirc), 64'h11223344);
        chk("lit_arm_cnt_hold", 64'(fifo_count), 64'd2);

        // Lane masking
        step(1'b1, 1'b1, 4'b0101, 32'hAABBCCDD, 1'b0);
        chk("lit_mask_data", 64'(data_out_active), 64'h00BB00DD);
        chk("lit_mask_vld",  64'(valid_out_active), 64'h5);
        chk("lit_mask_cnt",  64'(fwd_count), 64'd2);

        // Deactivation edge still forwards; then idle holds data and drains FIFO
        step(1'b1, 1'b0, 4'hF, 32'h12345678, 1'b0);
        chk("lit_deact_fwd", 64'(data_out_active), 64'h12345678);
        chk("lit_deact_cnt", 64'(fwd_count), 64'd3);
        step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
        chk("lit_idle_vld",  64'(valid_out_active), 64'd0);
        chk("lit_idle_hold", 64'(data_out_active), 64'h12345678);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
        chk("lit_drained", 64'(fifo_count), 64'd0);

        // Overflow: 6 pushes into a 4-deep FIFO, no drain
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 4'hF, 32'hA0A0A000 + 32'(i), 1'b0);
            if (i == 3) chk("lit_ovf_full", 64'(fifo_full), 64'd1);
        end
        chk("lit_ovf_drop",  64'(drop_count), 64'd2);
        chk("lit_ovf_count", 64'(fifo_count), 64'd4);
        chk("lit_ovf_head",  64'(data_out_recirc), 64'hA0A0A000);
        for (int k = 0; k < 4; k++) begin
            chk("lit_ovf_drain", 64'(data_out_recirc), 64'(32'hA0A0A000 + 32'(k)));
            step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
        end
        chk("lit_ovf_empty", 64'(valid_out_recirc), 64'd0);

        // Full push+pop
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 4'hF, 32'hB0B0B000 + 32'(i), 1'b0);
        step(1'b1, 1'b0, 4'hF, 32'hB0B0B004, 1'b1);
        chk("lit_pp_count", 64'(fifo_count), 64'd4);
        chk("lit_pp_drop",  64'(drop_count), 64'd2);
        for (int k = 1; k <= 4; k++) begin
            chk("lit_pp_order", 64'(data_out_recirc), 64'(32'hB0B0B000 + 32'(k)));
            step(1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
        end

        // Glitch rejection after a mid-run reset
        step(1'b0, 1'b0, 4'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 4'hF, 32'hC0C0C000, 1'b0);
        step(1'b1, 1'b1, 4'hF, 32'hC0C0C001, 1'b0);
        step(1'b1, 1'b0, 4'hF, 32'hC0C0C002, 1'b0);
        step(1'b1, 1'b0, 4'hF, 32'hC0C0C003, 1'b0);
        chk("lit_glitch_fwd",   64'(fwd_count), 64'd0);
        chk("lit_glitch_count", 64'(fifo_count), 64'd4);
        chk("lit_glitch_vld",   64'(valid_out_active), 64'd0);

        // Randomized traffic
        a = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) a = ~a;
            w = $urandom;
            step(($urandom_range(199) != 0), a,
                 ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom),
                 w, ($urandom_range(2) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
